uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Control and buffering block that wraps the UART receiver.
- Generates the receiver's 16x-oversampling s_tick from a programmable divisor.
- Captures each completed frame into a first-word-fall-through FIFO, which a host drains with a valid/ready handshake.
- Counts parity-failed frames and overrun (FIFO-full) drops; raises a level interrupt on FIFO threshold.

Parameters:
- FRAME_WIDTH, 8, data bits per frame (must match receiver).
- DEPTH, 8, FIFO entries; power of 2, >= 2.
- DIV_WIDTH, 16, width of baud divisor.
- CNT_WIDTH, 8, width of each saturating error counter.
- IRQ_THRESH, 4, FIFO level at or above which rx_irq asserts; 1..DEPTH.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  tick generator run; 0 = generator held idle.
- baud_div  input  DIV_WIDTH  s_tick period minus 1, in clk cycles.
- s_tick  output  1  oversampling strobe to receiver.
- rx_done_tick  input  1  receiver frame-complete pulse.
- rx_data_valid  input  1  receiver parity-OK flag, qualified by rx_done_tick.
- rx_dout  input  FRAME_WIDTH  receiver parallel data.
- m_data  output  FRAME_WIDTH  FIFO head data.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  host accepts m_data.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy.
- parity_err_cnt  output  CNT_WIDTH  frames dropped for parity failure.
- overrun_cnt  output  CNT_WIDTH  good frames dropped because FIFO full.
- clear_errs  input  1  synchronous clear of both counters.
- rx_irq  output  1  fifo_level >= IRQ_THRESH.

Behaviour:
- Reset (async, reset_n=0), all registered state zero:
  - s_tick=0, divider count=0, FIFO empty, m_valid=0, fifo_level=0, both counters 0, rx_irq=0.
  - m_data is don't-care while m_valid=0.
  - Reset mid-frame discards FIFO contents; no partial state survives.
- Tick generator:
  - Registered counter div_cnt.
  - enable=0: div_cnt<=0, s_tick<=0.
  - enable=1: if div_cnt >= baud_div then div_cnt<=0 and s_tick<=1; else div_cnt<=div_cnt+1 and s_tick<=0.
  - Period is baud_div+1 cycles; s_tick is high for exactly one cycle. baud_div=0 gives s_tick high every cycle after the first enabled edge.
  - A divisor change takes effect immediately. If div_cnt exceeds the new divisor, the >= compare fires on the next edge, so there is no wrap to 2^DIV_WIDTH.
  - First s_tick occurs baud_div+1 edges after enable rises.
- Frame capture, evaluated per rising edge with rx_done_tick=1:
  - rx_data_valid=0: frame discarded; parity_err_cnt+1, saturating at all-ones.
  - rx_data_valid=1, FIFO not full: push rx_dout.
  - rx_data_valid=1, FIFO full and pop this cycle: push accepted, level unchanged.
  - rx_data_valid=1, FIFO full, no pop: frame discarded; overrun_cnt+1, saturating.
  - rx_done_tick=0: rx_data_valid and rx_dout are ignored.
- Capture is independent of enable; frames still arriving after enable drops are buffered.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH; fifo_level is tracked explicitly.
  - m_valid = (fifo_level != 0). m_data = mem[rd_ptr], combinational from head, first-word fall-through.
  - Pop occurs when m_valid && m_ready. m_ready while empty has no effect.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - A pushed word is visible on m_data/m_valid the cycle after the push edge (1-cycle latency).
- Counters:
  - clear_errs=1 zeroes both counters on that edge and has priority over a same-cycle increment (that event is lost).
  - Counters hold once saturated until cleared.
- rx_irq is registered from the next-state level: it asserts on the same edge the level reaches IRQ_THRESH and drops on the edge the level falls below it.

Test Plan:
- Divisor: baud_div=9, enable=1 for 100 cycles -> s_tick one-cycle pulses every 10 cycles, first at edge 10; enable=0 -> s_tick stays 0 and count resets.
- Capture/drain: push 0x55, 0xA3, 0x0F with rx_data_valid=1, m_ready=0 -> fifo_level=3, m_data=0x55; assert m_ready -> 0x55, 0xA3, 0x0F in order, then m_valid=0.
- Overrun: DEPTH=8, 10 good frames with m_ready=0 -> fifo_level=8, overrun_cnt=2, FIFO holds first 8 frames. Full push with same-cycle pop -> level stays 8, overrun_cnt unchanged.
- Parity: 3 frames with rx_data_valid=0 -> parity_err_cnt=3, fifo_level unchanged. clear_errs coincident with a 4th bad frame -> counter=0.
- Saturation/wrap: 300 bad frames -> parity_err_cnt=255. Fill and drain 20 frames continuously -> pointers wrap, data order intact.
- IRQ/reset: fill to 4 -> rx_irq=1; pop 1 -> rx_irq=0. Assert reset_n=0 mid-stream -> all outputs 0 immediately, FIFO empty after release.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Control and buffering wrapper for a UART receiver: programmable 16x tick
// generator, FWFT receive FIFO with valid/ready drain, error counters, level IRQ.
module uart_rx_ctrl #(
  parameter int unsigned FRAME_WIDTH = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned IRQ_THRESH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [DIV_WIDTH-1:0]       baud_div,
  output logic                       s_tick,
  input  logic                       rx_done_tick,
  input  logic                       rx_data_valid,
  input  logic [FRAME_WIDTH-1:0]     rx_dout,
  output logic [FRAME_WIDTH-1:0]     m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]       parity_err_cnt,
  output logic [CNT_WIDTH-1:0]       overrun_cnt,
  input  logic                       clear_errs,
  output logic                       rx_irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [FRAME_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [LVL_W-1:0]       level;
  logic [LVL_W-1:0]       level_nxt;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   parity_evt;
  logic                   overrun_evt;

  // A >= compare (not ==) lets a shrinking divisor take effect on the next edge
  // instead of counting all the way round to 2^DIV_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      s_tick  <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      s_tick  <= 1'b0;
    end else if (div_cnt >= baud_div) begin
      div_cnt <= '0;
      s_tick  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      s_tick  <= 1'b0;
    end
  end

  // A full FIFO still accepts a good frame when the head is popped on the same edge.
  assign full        = (level == LVL_W'(DEPTH));
  assign m_valid     = (level != '0);
  assign pop         = m_valid && m_ready;
  assign push        = rx_done_tick && rx_data_valid && (!full || pop);
  assign overrun_evt = rx_done_tick && rx_data_valid && full && !pop;
  assign parity_evt  = rx_done_tick && !rx_data_valid;
  assign m_data      = mem[rd_ptr];
  assign fifo_level  = level;

  always_comb begin
    // NOTE: default first so every path assigns level_nxt and no latch is inferred.
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // NOTE: storage carries no reset; contents are unobservable while level is 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      rx_irq <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level  <= level_nxt;
      rx_irq <= (level_nxt >= LVL_W'(IRQ_THRESH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_cnt <= '0;
      overrun_cnt    <= '0;
    end else if (clear_errs) begin
      parity_err_cnt <= '0;
      overrun_cnt    <= '0;
    end else begin
      if (parity_evt && (parity_err_cnt != '1)) parity_err_cnt <= parity_err_cnt + 1'b1;
      if (overrun_evt && (overrun_cnt != '1))   overrun_cnt    <= overrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with default parameters.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] baud_div;
  logic        s_tick;
  logic        rx_done_tick;
  logic        rx_data_valid;
  logic [7:0]  rx_dout;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  fifo_level;
  logic [7:0]  parity_err_cnt;
  logic [7:0]  overrun_cnt;
  logic        clear_errs;
  logic        rx_irq;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .baud_div(baud_div),
    .s_tick(s_tick), .rx_done_tick(rx_done_tick), .rx_data_valid(rx_data_valid),
    .rx_dout(rx_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .parity_err_cnt(parity_err_cnt),
    .overrun_cnt(overrun_cnt), .clear_errs(clear_errs), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic ok);
    rx_done_tick  = 1'b1;
    rx_data_valid = ok;
    rx_dout       = d;
    step();
    rx_done_tick  = 1'b0;
    rx_data_valid = 1'b0;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] cap_vec[3] = '{8'h55, 8'hA3, 8'h0F};

  initial begin
    reset_n = 1'b0; enable = 1'b0; baud_div = 16'd9;
    rx_done_tick = 1'b0; rx_data_valid = 1'b0; rx_dout = '0;
    m_ready = 1'b0; clear_errs = 1'b0;
    #1;
    check("rst_s_tick", s_tick, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_par", parity_err_cnt, 0);
    check("rst_ovr", overrun_cnt, 0);
    check("rst_irq", rx_irq, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Tick generator: period 10, first pulse on the 10th enabled edge.
    enable = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      check("tick_div9", s_tick, ((k % 10) == 0) ? 1 : 0);
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("tick_disabled", s_tick, 0);
    end
    enable = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    check("tick_restart_low", s_tick, 0);
    // div_cnt is now 7; shrinking divisor to 3 fires on the very next edge.
    baud_div = 16'd3;
    step();
    check("tick_shrink_fire", s_tick, 1);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("tick_div3_low", s_tick, 0);
    end
    step();
    check("tick_div3_fire", s_tick, 1);
    enable = 1'b0; baud_div = 16'd0;
    step();
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("tick_div0", s_tick, 1);
    end
    enable = 1'b0;
    step();
    check("tick_off", s_tick, 0);

    // Capture and drain, with IRQ at level 4.
    foreach (cap_vec[i]) send(cap_vec[i], 1'b1);
    check("cap_level3", fifo_level, 3);
    check("cap_head", m_data, 8'h55);
    check("cap_valid", m_valid, 1);
    check("irq_below", rx_irq, 0);
    send(8'h77, 1'b1);
    check("irq_at4", rx_irq, 1);
    m_ready = 1'b1;
    step();
    check("irq_drop", rx_irq, 0);
    check("irq_level3", fifo_level, 3);
    check("drain_a3", m_data, 8'hA3);
    step();
    check("drain_0f", m_data, 8'h0F);
    step();
    check("drain_77", m_data, 8'h77);
    step();
    check("drain_empty", m_valid, 0);
    step();
    check("ready_when_empty", fifo_level, 0);
    m_ready = 1'b0;

    // Overrun: 10 good frames into an 8-deep FIFO.
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), 1'b1);
    check("ovr_level", fifo_level, 8);
    check("ovr_cnt", overrun_cnt, 2);
    check("ovr_head", m_data, 8'h10);
    m_ready = 1'b1;
    send(8'hEE, 1'b1);
    check("full_pushpop_level", fifo_level, 8);
    check("full_pushpop_ovr", overrun_cnt, 2);
    for (int i = 1; i < 8; i++) begin
      check("ovr_drain", m_data, 8'h10 + 8'(i));
      step();
    end
    check("ovr_drain_last", m_data, 8'hEE);
    step();
    check("ovr_empty", m_valid, 0);
    m_ready = 1'b0;

    // Parity errors and clear priority.
    for (int i = 0; i < 3; i++) send(8'hC0, 1'b0);
    check("par_cnt3", parity_err_cnt, 3);
    check("par_level", fifo_level, 0);
    clear_errs = 1'b1;
    send(8'hC1, 1'b0);
    clear_errs = 1'b0;
    check("clr_par", parity_err_cnt, 0);
    check("clr_ovr", overrun_cnt, 0);

    // Saturation: 300 consecutive bad frames.
    rx_done_tick = 1'b1; rx_data_valid = 1'b0;
    for (int i = 0; i < 300; i++) step();
    rx_done_tick = 1'b0;
    check("par_sat", parity_err_cnt, 255);
    step();
    check("par_hold", parity_err_cnt, 255);

    // Continuous streaming through the FIFO with a queue scoreboard.
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_valid) check("wrap_data", m_data, exp_q.pop_front());
      rx_done_tick = 1'b1; rx_data_valid = 1'b1; rx_dout = 8'h3C ^ 8'(i * 7);
      step();
      exp_q.push_back(8'h3C ^ 8'(i * 7));
    end
    rx_done_tick = 1'b0; rx_data_valid = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      check("wrap_tail", m_data, exp_q.pop_front());
      step();
    end
    check("wrap_q_empty", exp_q.size(), 0);
    check("wrap_empty", m_valid, 0);
    m_ready = 1'b0;

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b1);
    enable = 1'b1; baud_div = 16'd0;
    step();
    check("pre_rst_irq", rx_irq, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_level", fifo_level, 0);
    check("arst_irq", rx_irq, 0);
    check("arst_tick", s_tick, 0);
    check("arst_par", parity_err_cnt, 0);
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_valid", m_valid, 0);
    check("post_rst_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
